// File: rtl/coherence_bus_arbiter.sv
// Two-core snoop bus arbiter: round-robin pick, snoop of the other cache,
// optional shared-memory fill, then a one-cycle grant to the requester.
module coherence_bus_arbiter #(
    parameter int ADDR_W       = 11,
    parameter int SNOOP_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              read_miss0,
    input  logic              read_miss1,
    input  logic              write_miss0,
    input  logic              write_miss1,
    input  logic              invalidate0,
    input  logic              invalidate1,
    input  logic [ADDR_W-1:0] BICO0,
    input  logic [ADDR_W-1:0] BICO1,
    input  logic              cpu_search_found0,
    input  logic              cpu_search_found1,
    output logic              grant0,
    output logic              grant1,
    output logic              cpu_datasel0,
    output logic              cpu_datasel1,
    output logic              cpu_search0,
    output logic              cpu_search1,
    output logic [ADDR_W-1:0] BOCI0,
    output logic [ADDR_W-1:0] BOCI1,
    output logic              invalidate_from_other_cpu0,
    output logic              invalidate_from_other_cpu1,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_rdy
);

    typedef enum logic [1:0] {IDLE, SNOOP, MEM, DONE} state_t;
    typedef enum logic [1:0] {REQ_READ = 2'd0, REQ_WRITE = 2'd1, REQ_INV = 2'd2} req_t;

    localparam logic [3:0] SNOOP_LAST = 4'(SNOOP_CYCLES - 1);

    state_t              state, state_next;
    logic                w;
    req_t                req_type;
    logic [ADDR_W-1:0]   addr;
    logic                found;
    logic [3:0]          cnt;
    logic                last;

    logic req0, req1, any_req, win, snoop_found, snoop_last;
    req_t type0, type1;

    assign req0    = read_miss0 | write_miss0 | invalidate0;
    assign req1    = read_miss1 | write_miss1 | invalidate1;
    assign any_req = req0 | req1;
    // CPU0 wins when alone, or on a tie when CPU1 was served last.
    assign win     = (req0 && (!req1 || last)) ? 1'b0 : 1'b1;

    assign type0 = invalidate0 ? REQ_INV : (write_miss0 ? REQ_WRITE : REQ_READ);
    assign type1 = invalidate1 ? REQ_INV : (write_miss1 ? REQ_WRITE : REQ_READ);

    assign snoop_found = w ? cpu_search_found0 : cpu_search_found1;
    assign snoop_last  = (cnt == SNOOP_LAST);

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: default first so no path through this block leaves state_next
        // unassigned, which would otherwise infer a latch.
        state_next = state;
        case (state)
            IDLE:  if (any_req) state_next = SNOOP;
            SNOOP: if (snoop_last)
                       state_next = (req_type == REQ_INV || snoop_found) ? DONE : MEM;
            MEM:   if (mem_rdy) state_next = DONE;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            w        <= 1'b0;
            req_type <= REQ_READ;
            addr     <= '0;
            found    <= 1'b0;
            cnt      <= '0;
            last     <= 1'b1;
        end else begin
            case (state)
                IDLE: if (any_req) begin
                    w        <= win;
                    req_type <= win ? type1 : type0;
                    addr     <= win ? BICO1 : BICO0;
                    cnt      <= '0;
                end
                SNOOP: begin
                    cnt <= cnt + 4'd1;
                    // An upgrade never takes data from the other cache.
                    if (snoop_last) found <= (req_type != REQ_INV) && snoop_found;
                end
                DONE: last <= w;
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only: no input reaches an output.
    always_comb begin
        grant0                     = 1'b0;
        grant1                     = 1'b0;
        cpu_datasel0               = 1'b0;
        cpu_datasel1               = 1'b0;
        cpu_search0                = 1'b0;
        cpu_search1                = 1'b0;
        BOCI0                      = '0;
        BOCI1                      = '0;
        invalidate_from_other_cpu0 = 1'b0;
        invalidate_from_other_cpu1 = 1'b0;
        mem_re                     = 1'b0;
        mem_addr                   = '0;
        case (state)
            SNOOP: begin
                if (w) begin
                    cpu_search0                = 1'b1;
                    BOCI0                      = addr;
                    invalidate_from_other_cpu0 = (req_type != REQ_READ);
                end else begin
                    cpu_search1                = 1'b1;
                    BOCI1                      = addr;
                    invalidate_from_other_cpu1 = (req_type != REQ_READ);
                end
            end
            MEM: begin
                mem_re   = 1'b1;
                mem_addr = addr;
            end
            DONE: begin
                if (w) begin
                    grant1       = 1'b1;
                    cpu_datasel1 = found;
                end else begin
                    grant0       = 1'b1;
                    cpu_datasel0 = found;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_arbiter.sv
// Directed self-checking bench for coherence_bus_arbiter; a second instance
// with SNOOP_CYCLES=3 shares the inputs for the multi-cycle snoop case.
module tb_coherence_bus_arbiter;

    localparam int AW = 11;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic read_miss0, read_miss1, write_miss0, write_miss1, invalidate0, invalidate1;
    logic [AW-1:0] BICO0, BICO1;
    logic found0, found1, mem_rdy;

    logic grant0, grant1, datasel0, datasel1, search0, search1, inv0, inv1, mem_re;
    logic [AW-1:0] BOCI0, BOCI1, mem_addr;

    logic d3_grant0, d3_grant1, d3_datasel0, d3_datasel1, d3_search0, d3_search1;
    logic d3_inv0, d3_inv1, d3_mem_re;
    logic [AW-1:0] d3_BOCI0, d3_BOCI1, d3_mem_addr;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    coherence_bus_arbiter #(.ADDR_W(AW), .SNOOP_CYCLES(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .read_miss0(read_miss0), .read_miss1(read_miss1),
        .write_miss0(write_miss0), .write_miss1(write_miss1),
        .invalidate0(invalidate0), .invalidate1(invalidate1),
        .BICO0(BICO0), .BICO1(BICO1),
        .cpu_search_found0(found0), .cpu_search_found1(found1),
        .grant0(grant0), .grant1(grant1),
        .cpu_datasel0(datasel0), .cpu_datasel1(datasel1),
        .cpu_search0(search0), .cpu_search1(search1),
        .BOCI0(BOCI0), .BOCI1(BOCI1),
        .invalidate_from_other_cpu0(inv0), .invalidate_from_other_cpu1(inv1),
        .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdy(mem_rdy)
    );

    coherence_bus_arbiter #(.ADDR_W(AW), .SNOOP_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .read_miss0(read_miss0), .read_miss1(read_miss1),
        .write_miss0(write_miss0), .write_miss1(write_miss1),
        .invalidate0(invalidate0), .invalidate1(invalidate1),
        .BICO0(BICO0), .BICO1(BICO1),
        .cpu_search_found0(found0), .cpu_search_found1(found1),
        .grant0(d3_grant0), .grant1(d3_grant1),
        .cpu_datasel0(d3_datasel0), .cpu_datasel1(d3_datasel1),
        .cpu_search0(d3_search0), .cpu_search1(d3_search1),
        .BOCI0(d3_BOCI0), .BOCI1(d3_BOCI1),
        .invalidate_from_other_cpu0(d3_inv0), .invalidate_from_other_cpu1(d3_inv1),
        .mem_re(d3_mem_re), .mem_addr(d3_mem_addr), .mem_rdy(mem_rdy)
    );

    wire [41:0] dut_outs = {grant0, grant1, datasel0, datasel1, search0, search1,
                            inv0, inv1, mem_re, BOCI0, BOCI1, mem_addr};
    wire [41:0] d3_outs  = {d3_grant0, d3_grant1, d3_datasel0, d3_datasel1, d3_search0,
                            d3_search1, d3_inv0, d3_inv1, d3_mem_re, d3_BOCI0, d3_BOCI1,
                            d3_mem_addr};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        read_miss0 = 0; read_miss1 = 0; write_miss0 = 0; write_miss1 = 0;
        invalidate0 = 0; invalidate1 = 0; BICO0 = '0; BICO1 = '0;
        found0 = 0; found1 = 0; mem_rdy = 0;
    endtask

    // Leaves the bench 1 time unit after a rising edge with both DUTs in IDLE.
    task automatic do_reset();
        clear_inputs();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_outs !== 42'd0) $display("FAIL reset_outs got %h exp 0", dut_outs);
        else passed++;
        checks++;
        if (d3_outs !== 42'd0) $display("FAIL reset_outs_d3 got %h exp 0", d3_outs);
        else passed++;
        step();
        rst_n = 1'b1;
        read_miss0 = 1; BICO0 = 11'h0F0; found1 = 0;
        step();
        step();
        checks++;
        if ({mem_re, mem_addr} !== {1'b1, 11'h0F0})
            $display("FAIL reset_pre_mem got %b/%h exp 1/0f0", mem_re, mem_addr);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (dut_outs !== 42'd0) $display("FAIL reset_mid_mem got %h exp 0", dut_outs);
        else passed++;
        read_miss1 = 1; BICO1 = 11'h333; found1 = 1;
        step();
        rst_n = 1'b1;
        step();
        checks++;
        if ({search1, search0, BOCI1} !== {1'b1, 1'b0, 11'h0F0})
            $display("FAIL reset_first_tie got %b%b/%h exp 10/0f0", search1, search0, BOCI1);
        else passed++;
        step();
        checks++;
        if ({grant0, grant1} !== 2'b10)
            $display("FAIL reset_tie_grant got %b%b exp 10", grant0, grant1);
        else passed++;
    endtask

    task automatic test_cache_to_cache();
        do_reset();
        read_miss0 = 1; BICO0 = 11'h155; found1 = 1; mem_rdy = 1;
        step();
        checks++;
        if ({search1, BOCI1, inv1, search0} !== {1'b1, 11'h155, 1'b0, 1'b0})
            $display("FAIL c2c_snoop got %b/%h/%b/%b exp 1/155/0/0", search1, BOCI1, inv1, search0);
        else passed++;
        step();
        checks++;
        if ({grant0, datasel0, grant1, mem_re} !== 4'b1100)
            $display("FAIL c2c_grant got %b%b%b%b exp 1100", grant0, datasel0, grant1, mem_re);
        else passed++;
        read_miss0 = 0; mem_rdy = 0;
        step();
        checks++;
        if (dut_outs !== 42'd0) $display("FAIL c2c_idle got %h exp 0", dut_outs);
        else passed++;
    endtask

    task automatic test_write_miss_mem();
        do_reset();
        write_miss1 = 1; BICO1 = 11'h7FF; found0 = 0;
        step();
        checks++;
        if ({search0, BOCI0, inv0} !== {1'b1, 11'h7FF, 1'b1})
            $display("FAIL wm_snoop got %b/%h/%b exp 1/7ff/1", search0, BOCI0, inv0);
        else passed++;
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({mem_re, mem_addr, grant1} !== {1'b1, 11'h7FF, 1'b0})
                $display("FAIL wm_mem%0d got %b/%h/%b exp 1/7ff/0", i, mem_re, mem_addr, grant1);
            else passed++;
            if (i == 2) mem_rdy = 1;
        end
        step();
        checks++;
        if ({grant1, datasel1, grant0, mem_re} !== 4'b1000)
            $display("FAIL wm_grant got %b%b%b%b exp 1000", grant1, datasel1, grant0, mem_re);
        else passed++;
        write_miss1 = 0; mem_rdy = 0;
    endtask

    task automatic test_invalidate();
        do_reset();
        invalidate0 = 1; read_miss0 = 1; BICO0 = 11'h2A5; found1 = 1;
        step();
        checks++;
        if ({search1, BOCI1, inv1} !== {1'b1, 11'h2A5, 1'b1})
            $display("FAIL inv_snoop got %b/%h/%b exp 1/2a5/1", search1, BOCI1, inv1);
        else passed++;
        step();
        checks++;
        if ({grant0, datasel0, mem_re} !== 3'b100)
            $display("FAIL inv_grant got %b%b%b exp 100", grant0, datasel0, mem_re);
        else passed++;
        invalidate0 = 0; read_miss0 = 0;
        step();
        checks++;
        if (dut_outs !== 42'd0) $display("FAIL inv_idle got %h exp 0", dut_outs);
        else passed++;
    endtask

    task automatic test_fairness();
        do_reset();
        read_miss0 = 1; write_miss1 = 1; BICO0 = 11'h011; BICO1 = 11'h622;
        found0 = 1; found1 = 1;
        for (int t = 0; t < 4; t++) begin
            step();
            checks++;
            if (t % 2 == 0) begin
                if ({search1, search0, inv1, BOCI1} !== {1'b1, 1'b0, 1'b0, BICO0})
                    $display("FAIL fair_snoop%0d got %b%b%b/%h exp 100/%h", t, search1, search0, inv1, BOCI1, BICO0);
                else passed++;
            end else begin
                if ({search0, search1, inv0, BOCI0} !== {1'b1, 1'b0, 1'b1, BICO1})
                    $display("FAIL fair_snoop%0d got %b%b%b/%h exp 101/%h", t, search0, search1, inv0, BOCI0, BICO1);
                else passed++;
            end
            step();
            checks++;
            if ({grant0, grant1} !== ((t % 2 == 0) ? 2'b10 : 2'b01))
                $display("FAIL fair_grant%0d got %b%b exp %s", t, grant0, grant1, (t % 2 == 0) ? "10" : "01");
            else passed++;
            if (t % 2 == 0) BICO0 = BICO0 + 11'h100;
            else            BICO1 = BICO1 + 11'h010;
            step();
        end
        clear_inputs();
    endtask

    task automatic test_param_sweep();
        do_reset();
        read_miss0 = 1; BICO0 = 11'h0AA; found1 = 1;
        for (int i = 1; i <= 3; i++) begin
            step();
            checks++;
            if ({d3_search1, d3_BOCI1, d3_grant0, d3_mem_re} !== {1'b1, 11'h0AA, 1'b0, 1'b0})
                $display("FAIL sweep_snoop%0d got %b/%h/%b/%b exp 1/0aa/0/0", i, d3_search1, d3_BOCI1, d3_grant0, d3_mem_re);
            else passed++;
            if (i == 2) found1 = 0;
        end
        step();
        checks++;
        if ({d3_mem_re, d3_mem_addr, d3_grant0} !== {1'b1, 11'h0AA, 1'b0})
            $display("FAIL sweep_mem got %b/%h/%b exp 1/0aa/0", d3_mem_re, d3_mem_addr, d3_grant0);
        else passed++;
        mem_rdy = 1;
        step();
        checks++;
        if ({d3_grant0, d3_datasel0, d3_mem_re} !== 3'b100)
            $display("FAIL sweep_grant got %b%b%b exp 100", d3_grant0, d3_datasel0, d3_mem_re);
        else passed++;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_cache_to_cache();
        test_write_miss_mem();
        test_invalidate();
        test_fairness();
        test_param_sweep();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

endmodule
